// File: rtl/vreg_file_sb_pkg.sv
// Shared definitions for the vector/scalar register file.
// Decode and writeback use the same address and lane-vector types.
package vreg_file_sb_pkg;

  // Default geometry of the register file
  localparam int REG_SIZE = 8;   // bits per lane element / scalar register
  localparam int REG_QTY  = 4;   // registers per bank
  localparam int SEL_BITS = 2;   // index bits per bank
  localparam int VEC_SIZE = 4;   // lanes per vector register

  // Address MSB selects the scalar bank (1) or the vector bank (0)
  localparam int BANK_BIT = SEL_BITS;

  // One full vector register, lane 0 in the least significant bits
  typedef logic [VEC_SIZE*REG_SIZE-1:0] lane_vec_t;

  // Register address: {bank, index}
  typedef logic [SEL_BITS:0] reg_addr_t;

endpackage

// File: rtl/reg_scoreboard.sv
// Pending-write scoreboard: one busy bit per register, hazard stall and
// sticky writeback-error flag. Addresses are {bank, index}; the busy
// output packs the vector bank into the low half.
module reg_scoreboard
  import vreg_file_sb_pkg::*;
#(
  parameter int registerQuantity = REG_QTY,
  parameter int selectionBits    = SEL_BITS
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [selectionBits:0]        r_sel1_i,
  input  logic [selectionBits:0]        r_sel2_i,
  input  logic                          rd_en1_i,
  input  logic                          rd_en2_i,
  input  logic                          issue_en_i,
  input  logic [selectionBits:0]        issue_dst_i,
  input  logic                          wr_en_i,
  input  logic [selectionBits:0]        wr_addr_i,
  output logic                          stall_o,
  output logic [2*registerQuantity-1:0] busy_o,
  output logic                          wb_err_o
);

  localparam int DEPTH = 2**selectionBits;
  localparam int NADDR = 2*DEPTH;
  localparam int AW    = selectionBits+1;

  logic [NADDR-1:0] busy_w;   // busy bit per address (0 for unimplemented indices)
  logic [NADDR-1:0] clr_w;    // address cleared by this cycle's writeback
  logic [NADDR-1:0] pend_w;   // busy and not resolved by this cycle's writeback
  logic             stall_w;
  logic             set_en;
  logic             wb_err_q, wb_err_d;

  genvar gi;
  generate
    for (gi = 0; gi < NADDR; gi++) begin : g_bit
      localparam int BANK = gi / DEPTH;
      localparam int IDX  = gi % DEPTH;

      assign clr_w[gi] = wr_en_i && (wr_addr_i == AW'(gi));

      if (IDX < registerQuantity) begin : g_live
        logic bit_q, bit_d;

        // Issue set has priority over a same-cycle writeback clear
        always_comb begin
          bit_d = bit_q;
          if (clr_w[gi]) bit_d = 1'b0;
          if (set_en && (issue_dst_i == AW'(gi))) bit_d = 1'b1;
        end

        // Busy bit register
        always_ff @(posedge clk) begin
          if (reset) bit_q <= 1'b0;
          else       bit_q <= bit_d;
        end

        assign busy_w[gi] = bit_q;
        assign busy_o[BANK*registerQuantity+IDX] = bit_q;
      end else begin : g_dead
        assign busy_w[gi] = 1'b0;
      end
    end
  endgenerate

  // A same-cycle writeback resolves the hazard immediately (bypass)
  assign pend_w  = busy_w & ~clr_w;
  assign stall_w = (rd_en1_i   && pend_w[r_sel1_i]) ||
                   (rd_en2_i   && pend_w[r_sel2_i]) ||
                   (issue_en_i && pend_w[issue_dst_i]);
  assign set_en  = issue_en_i && !stall_w;

  // Sticky flag: writeback landed on a register nobody was waiting for
  always_comb begin
    wb_err_d = wb_err_q;
    if (wr_en_i && !busy_w[wr_addr_i]) wb_err_d = 1'b1;
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (reset) wb_err_q <= 1'b0;
    else       wb_err_q <= wb_err_d;
  end

  assign stall_o  = stall_w;
  assign wb_err_o = wb_err_q;

endmodule

// File: rtl/vreg_file_sb.sv
// Banked vector/scalar register file with two combinational read ports,
// lane-masked vector writes, scalar broadcast, write-to-read bypass and
// an integrated hazard scoreboard.
module vreg_file_sb
  import vreg_file_sb_pkg::*;
#(
  parameter int registerSize     = REG_SIZE,
  parameter int registerQuantity = REG_QTY,
  parameter int selectionBits    = SEL_BITS,
  parameter int vectorSize       = VEC_SIZE
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [selectionBits:0]             rSel1,
  input  logic [selectionBits:0]             rSel2,
  input  logic                               rdEn1,
  input  logic                               rdEn2,
  output logic [vectorSize*registerSize-1:0] operand1,
  output logic [vectorSize*registerSize-1:0] operand2,
  input  logic                               regWrEnVec,
  input  logic                               regWrEnSc,
  input  logic [vectorSize-1:0]              laneMask,
  input  logic [selectionBits:0]             regToWrite,
  input  logic [vectorSize*registerSize-1:0] dataIn,
  input  logic                               issueEn,
  input  logic [selectionBits:0]             issueDst,
  output logic                               stall,
  output logic [2*registerQuantity-1:0]      busy,
  output logic                               wbErr
);

  localparam int DEPTH = 2**selectionBits;
  localparam int W     = vectorSize*registerSize;

  logic [DEPTH-1:0]                   idx_valid;
  logic [selectionBits-1:0]           wr_idx;
  logic                               wr_sc, wr_vec, wr_en;
  logic [selectionBits:0]             wr_addr;
  logic [DEPTH-1:0][W-1:0]            vec_all;
  logic [DEPTH-1:0][registerSize-1:0] sc_all;
  logic [1:0][W-1:0]                  op_all;
  logic                               unused_wr_bank;

  // Writeback bank comes from the enables, not from the address MSB
  assign unused_wr_bank = regToWrite[selectionBits];
  assign wr_idx  = regToWrite[selectionBits-1:0];
  assign wr_sc   = regWrEnSc && idx_valid[wr_idx];
  assign wr_vec  = regWrEnVec && !regWrEnSc && idx_valid[wr_idx];
  assign wr_en   = wr_sc || wr_vec;
  assign wr_addr = {regWrEnSc, wr_idx};

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_store
      assign idx_valid[gi] = (gi < registerQuantity);

      if (gi < registerQuantity) begin : g_live
        logic [W-1:0]            vec_q, vec_d;
        logic [registerSize-1:0] sc_q, sc_d;

        // Apply this cycle's writeback to register gi of each bank
        always_comb begin
          vec_d = vec_q;
          sc_d  = sc_q;
          if (wr_vec && (wr_idx == selectionBits'(gi))) begin
            for (int l = 0; l < vectorSize; l++) begin
              if (laneMask[l]) vec_d[l*registerSize +: registerSize] = dataIn[l*registerSize +: registerSize];
            end
          end
          if (wr_sc && (wr_idx == selectionBits'(gi))) sc_d = dataIn[registerSize-1:0];
        end

        // Register storage
        always_ff @(posedge clk) begin
          if (reset) begin
            vec_q <= '0;
            sc_q  <= '0;
          end else begin
            vec_q <= vec_d;
            sc_q  <= sc_d;
          end
        end

        assign vec_all[gi] = vec_q;
        assign sc_all[gi]  = sc_q;
      end else begin : g_dead
        assign vec_all[gi] = '0;
        assign sc_all[gi]  = '0;
      end
    end

    for (gi = 0; gi < 2; gi++) begin : g_port
      logic [selectionBits:0]   sel;
      logic [selectionBits-1:0] sel_idx;
      logic [W-1:0]             rd;
      logic [registerSize-1:0]  lane_val;

      assign sel     = (gi == 0) ? rSel1 : rSel2;
      assign sel_idx = sel[selectionBits-1:0];

      // Read with bypass: scalars broadcast, unmasked vector lanes keep old data
      always_comb begin
        rd       = '0;
        lane_val = '0;
        if (sel[selectionBits]) begin
          lane_val = sc_all[sel_idx];
          if (wr_sc && (wr_idx == sel_idx)) lane_val = dataIn[registerSize-1:0];
          for (int l = 0; l < vectorSize; l++) rd[l*registerSize +: registerSize] = lane_val;
        end else begin
          rd = vec_all[sel_idx];
          for (int l = 0; l < vectorSize; l++) begin
            if (wr_vec && (wr_idx == sel_idx) && laneMask[l])
              rd[l*registerSize +: registerSize] = dataIn[l*registerSize +: registerSize];
          end
        end
      end

      assign op_all[gi] = rd;
    end
  endgenerate

  assign operand1 = op_all[0];
  assign operand2 = op_all[1];

  reg_scoreboard #(
    .registerQuantity(registerQuantity),
    .selectionBits   (selectionBits)
  ) u_scoreboard (
    .clk        (clk),
    .reset      (reset),
    .r_sel1_i   (rSel1),
    .r_sel2_i   (rSel2),
    .rd_en1_i   (rdEn1),
    .rd_en2_i   (rdEn2),
    .issue_en_i (issueEn),
    .issue_dst_i(issueDst),
    .wr_en_i    (wr_en),
    .wr_addr_i  (wr_addr),
    .stall_o    (stall),
    .busy_o     (busy),
    .wb_err_o   (wbErr)
  );

endmodule
